// File: rtl/pc_pkg.sv
// Shared command encoding and default reset address for the program counter with return stack.
package pc_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_INC   = 3'd1,
        CMD_LD    = 3'd2,
        CMD_CALL  = 3'd3,
        CMD_RET   = 3'd4,
        CMD_BRREL = 3'd5
    } pc_cmd_e;

    localparam int unsigned PC_ADDR_W_DEFAULT = 5;
    localparam int unsigned PC_RESET_ADDR     = 0;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address storage with depth counter and full/empty flags.
module pc_ret_stack #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] depth_q, depth_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             do_push, do_pop;

    assign full    = (depth_q == CNT_W'(DEPTH));
    assign empty   = (depth_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;

    // Read index is forced to 0 when empty so it never leaves the array range.
    assign wr_idx   = IDX_W'(depth_q);
    assign rd_idx   = empty ? '0 : IDX_W'(depth_q - CNT_W'(1));
    assign pop_data = mem[rd_idx];

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + CNT_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with hardware return-address stack, CALL/RET and sticky stack_err.
// Optional PC-relative branch enabled by defining PC_REL_BRANCH_EN.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = PC_ADDR_W_DEFAULT,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(PC_RESET_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_pc,
    input  logic              ld_pc,
    input  logic              call,
    input  logic              ret,
    input  logic              err_clr,
`ifdef PC_REL_BRANCH_EN
    input  logic              br_rel,
    input  logic [ADDR_W-1:0] br_off,
`endif
    input  logic [ADDR_W-1:0] ir_addr,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    pc_cmd_e           cmd;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, pop_data;
    logic              push, pop, err_set;
    logic              stack_err_q, stack_err_d;

    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        cmd = CMD_NONE;
        if (call) begin
            cmd = CMD_CALL;
        end else if (ret) begin
            cmd = CMD_RET;
`ifdef PC_REL_BRANCH_EN
        end else if (br_rel) begin
            cmd = CMD_BRREL;
`endif
        end else if (ld_pc) begin
            cmd = CMD_LD;
        end else if (inc_pc) begin
            cmd = CMD_INC;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (cmd)
            CMD_INC: pc_d = pc_inc;
            CMD_LD:  pc_d = ir_addr;
            CMD_CALL: begin
                if (stack_full) begin
                    err_set = 1'b1;
                end else begin
                    push = 1'b1;
                    pc_d = ir_addr;
                end
            end
            CMD_RET: begin
                if (stack_empty) begin
                    err_set = 1'b1;
                end else begin
                    pop  = 1'b1;
                    pc_d = pop_data;
                end
            end
`ifdef PC_REL_BRANCH_EN
            CMD_BRREL: pc_d = pc_q + br_off;
`endif
            default: ;
        endcase
    end

    // A fresh over/underflow wins over a simultaneous clear.
    always_comb begin
        stack_err_d = stack_err_q;
        if (err_set) begin
            stack_err_d = 1'b1;
        end else if (err_clr) begin
            stack_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_ADDR;
            stack_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            stack_err_q <= stack_err_d;
        end
    end

    pc_ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .pop_data  (pop_data),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign pc_addr   = pc_q;
    assign stack_err = stack_err_q;

endmodule
